// File: rtl/arraysp_pkg.sv
// arraysp_pipe shared definitions: clear/run FSM encoding,
// output latency bounds and the parity helper.
package arraysp_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  localparam int LAT_MIN  = 1;
  localparam int LAT_MAX  = 4;
  localparam int PAR_MAXW = 256;

  function automatic logic even_par(
    input logic [PAR_MAXW-1:0] x
  );
    return ^x;
  endfunction

endpackage

// File: rtl/ramspx.sv
// ramspx: single-port RAM primitive, synchronous write,
// registered read (1-cycle), no reset on array or output.
module ramspx #(
  parameter int ADDRBIT = 11,
  parameter int DEPTH   = 1536,
  parameter int WIDTH   = 32,
  parameter     TYPE    = "AUTO"
) (
  input  logic               clk,
  input  logic [ADDRBIT-1:0] a,
  input  logic               we,
  input  logic               re,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ai;

  assign ai = AW'(a);

  always_ff @(posedge clk) begin
    if (we) mem[ai] <= d;
    if (re) q <= mem[ai];
  end

endmodule

// File: rtl/arraysp_pipe.sv
// arraysp_pipe: single-port RAM wrapper with 1+LAT read latency,
// read-valid pipeline and clear sequencer. Parity: ARRAYSP_PARITY_EN.
module arraysp_pipe
  import arraysp_pkg::*;
#(
  parameter int ADDRBIT = 11,
  parameter int DEPTH   = 1536,
  parameter int WIDTH   = 32,
  parameter int LAT     = 1,
  parameter     TYPE    = "AUTO"
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [ADDRBIT-1:0] a,
  input  logic               we,
  input  logic               re,
  input  logic [WIDTH-1:0]   di,
  input  logic               clr,
`ifdef ARRAYSP_PARITY_EN
  input  logic               pinj,
  output logic               perr,
`endif
  output logic [WIDTH-1:0]   dout,
  output logic               dvld,
  output logic               busy
);

  localparam int L = (LAT < LAT_MIN) ? LAT_MIN :
                     (LAT > LAT_MAX) ? LAT_MAX : LAT;
`ifdef ARRAYSP_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif
  localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);

  state_e                    state_q, state_d;
  logic [ADDRBIT-1:0]        cnt_q, cnt_d;
  logic [L:0]                v_q, v_d;
  logic                      oor_q, oor_d;
  logic [L-1:0][WIDTH-1:0]   dat_q, dat_d;

  logic                      run, in_rng, wr_go, rd_go;
  logic                      ram_we, ram_re;
  logic [ADDRBIT-1:0]        ram_a;
  logic [RW-1:0]             ram_d, ram_q, wdata;

`ifdef ARRAYSP_PARITY_EN
  logic [L-1:0]              pe_q, pe_d;
  assign wdata = {even_par(PAR_MAXW'(di)) ^ pinj, di};
`else
  assign wdata = di;
`endif

  ramspx #(
    .ADDRBIT(ADDRBIT),
    .DEPTH  (DEPTH),
    .WIDTH  (RW),
    .TYPE   (TYPE)
  ) u_ram (
    .clk(clk),
    .a  (ram_a),
    .we (ram_we),
    .re (ram_re),
    .d  (ram_d),
    .q  (ram_q)
  );

  always_comb begin
    run     = (state_q == RUN);
    in_rng  = {1'b0, a} < (ADDRBIT+1)'(DEPTH);
    wr_go   = run & we;
    rd_go   = run & re & ~we;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = RUN;
    end
    if (clr) begin
      state_d = CLR;
      cnt_d   = '0;
    end
    // the clear sequencer owns the RAM port while not running
    ram_we = run ? (wr_go & in_rng) : 1'b1;
    ram_re = rd_go & in_rng;
    ram_a  = run ? a : cnt_q;
    ram_d  = run ? wdata : '0;
    v_d    = {v_q[L-1:0], rd_go};
    oor_d  = rd_go & ~in_rng;
    dat_d  = dat_q;
    if (v_q[0]) dat_d[0] = oor_q ? '0 : ram_q[WIDTH-1:0];
    for (int k = 1; k < L; k++)
      if (v_q[k]) dat_d[k] = dat_q[k-1];
`ifdef ARRAYSP_PARITY_EN
    pe_d = pe_q;
    if (v_q[0])
      pe_d[0] = ~oor_q &
        (even_par(PAR_MAXW'(ram_q[WIDTH-1:0])) != ram_q[WIDTH]);
    for (int k = 1; k < L; k++)
      if (v_q[k]) pe_d[k] = pe_q[k-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= CLR;
      cnt_q   <= '0;
      v_q     <= '0;
      oor_q   <= 1'b0;
      dat_q   <= '0;
`ifdef ARRAYSP_PARITY_EN
      pe_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      oor_q   <= oor_d;
      dat_q   <= dat_d;
`ifdef ARRAYSP_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  assign dout = dat_q[L-1];
  assign dvld = v_q[L];
  assign busy = (state_q == CLR);
`ifdef ARRAYSP_PARITY_EN
  assign perr = pe_q[L-1] & v_q[L];
`endif

endmodule
